// File: rtl/sync_frame_tx_if.sv
// sync_frame_tx_if: frame request/data and serial status bundle between a client (master) and sync_frame_tx (slave)
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic start;
  logic [DATA_W-1:0] data_in;
  logic ready;
  logic x_out;
  logic frame_active;
  logic done;
  modport master(output start, data_in, input ready, x_out, frame_active, done);
  modport slave(input start, data_in, output ready, x_out, frame_active, done);
endinterface

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serialises sync word, payload (MSB first), even parity and a zero gap bit, each held DIV clocks
//   CLOCK_50, rst (sync, active-high)
//   bus.start/bus.data_in in; bus.ready, bus.x_out, bus.frame_active, bus.done out
module sync_frame_tx #(
  parameter logic [6:0] SYNC = 7'b1100110,
  parameter int DATA_W = 8,
  parameter int DIV = 1
) (
  input logic CLOCK_50,
  input logic rst,
  sync_frame_tx_if.slave bus
);
  localparam int MAXB = DATA_W > 7 ? DATA_W : 7;
  localparam int IW = $clog2(MAXB);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;
  state_t state = S_IDLE;
  state_t state_n;
  logic [DATA_W-1:0] sr = '0;
  logic [DATA_W-1:0] sr_n;
  logic [IW-1:0] idx = '0;
  logic [IW-1:0] idx_n;
  logic [DW-1:0] div = '0;
  logic [DW-1:0] div_n;
  logic x_q = 1'b0;
  logic x_n;
  logic done_q = 1'b0;
  logic done_n;
  logic bit_end;
  assign bit_end = div == '0;
  always_ff @(posedge CLOCK_50)
    if (rst) begin
      state <= S_IDLE;
      sr <= '0;
      idx <= '0;
      div <= '0;
      x_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      idx <= idx_n;
      div <= div_n;
      x_q <= x_n;
      done_q <= done_n;
    end
  // x_n is the bit that x_out will carry from the next edge, so each bit is registered on its boundary
  always_comb begin
    state_n = state;
    sr_n = sr;
    idx_n = idx;
    div_n = bit_end ? DW'(DIV - 1) : div - DW'(1);
    x_n = x_q;
    done_n = 1'b0;
    case (state)
      S_IDLE: begin
        div_n = '0;
        x_n = 1'b0;
        if (bus.start) begin
          state_n = S_SYNC;
          sr_n = bus.data_in;
          idx_n = IW'(6);
          div_n = DW'(DIV - 1);
          x_n = SYNC[6];
        end
      end
      S_SYNC:
        if (bit_end) begin
          if (idx == '0) begin
            state_n = S_DATA;
            idx_n = IW'(DATA_W - 1);
            x_n = sr[DATA_W-1];
          end else begin
            idx_n = idx - IW'(1);
            x_n = SYNC[idx-IW'(1)];
          end
        end
      S_DATA:
        if (bit_end) begin
          if (idx == '0) begin
            state_n = S_PARITY;
            x_n = ^sr;
          end else begin
            idx_n = idx - IW'(1);
            x_n = sr[idx-IW'(1)];
          end
        end
      S_PARITY:
        if (bit_end) begin
          state_n = S_GAP;
          x_n = 1'b0;
        end
      S_GAP:
        if (bit_end) begin
          state_n = S_IDLE;
          done_n = 1'b1;
          div_n = '0;
        end
      default: begin
        state_n = S_IDLE;
        idx_n = '0;
        div_n = '0;
        x_n = 1'b0;
      end
    endcase
  end
  always_comb begin
    bus.ready = state == S_IDLE;
    bus.frame_active = state != S_IDLE;
  end
  assign bus.x_out = x_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: random and directed frames on DIV=1 and DIV=4 instances against a frame-position model
module tb_sync_frame_tx;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] data = 8'h00;
  sync_frame_tx_if b1();
  sync_frame_tx_if b4();
  assign b1.start = start;
  assign b1.data_in = data;
  assign b4.start = start;
  assign b4.data_in = data;
  sync_frame_tx #(.DIV(1)) dut1(.CLOCK_50(clk), .rst(rst), .bus(b1));
  sync_frame_tx #(.DIV(4)) dut4(.CLOCK_50(clk), .rst(rst), .bus(b4));
  int checks = 0;
  int errors = 0;
  int pos[2] = '{-1, -1};
  int dv[2] = '{1, 4};
  logic dn[2] = '{1'b0, 1'b0};
  logic [16:0] fr[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [16:0] frame_bits(input logic [7:0] d);
    return {7'b1100110, d, ^d, 1'b0};
  endfunction
  // pos is the cycle index inside the frame (-1 = idle); a frame lasts 17*DIV cycles
  task automatic model();
    for (int k = 0; k < 2; k++) begin
      dn[k] = 1'b0;
      if (rst) pos[k] = -1;
      else if (pos[k] < 0) begin
        if (start) begin
          pos[k] = 0;
          fr[k] = frame_bits(data);
        end
      end else begin
        pos[k]++;
        if (pos[k] == 17 * dv[k]) begin
          pos[k] = -1;
          dn[k] = 1'b1;
        end
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic xe;
      xe = pos[k] >= 0 ? fr[k][16 - pos[k] / dv[k]] : 1'b0;
      check($sformatf("x_out div%0d", dv[k]), k == 0 ? b1.x_out : b4.x_out, xe);
      check($sformatf("ready div%0d", dv[k]), k == 0 ? b1.ready : b4.ready, pos[k] < 0);
      check($sformatf("frame_active div%0d", dv[k]), k == 0 ? b1.frame_active : b4.frame_active, pos[k] >= 0);
      check($sformatf("done div%0d", dv[k]), k == 0 ? b1.done : b4.done, dn[k]);
    end
  endtask
  task automatic cyc(input logic s, input logic [7:0] d, input logic r);
    start = s;
    data = d;
    rst = r;
    @(posedge clk);
    model();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    @(negedge clk);
    repeat (2) cyc(1'b1, 8'h55, 1'b1);
    cyc(1'b1, 8'hA5, 1'b0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0);
    repeat (75) cyc(1'b0, 8'hC3, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    repeat (6) cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    repeat (15) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0);
    repeat (7) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    repeat (80) cyc(1'b1, 8'h81, 1'b0);
    repeat (3000) cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_frame_tx.md
SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

Interface
REQ-001 SYNC parameter, default 7'b1100110: sync word, sent MSB first.
REQ-002 DATA_W parameter, default 8: payload width in bits.
REQ-003 DIV parameter, default 1: CLOCK_50 cycles per serial bit; legal values 1..1024.
REQ-004 CLOCK_50  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  frame request; sampled only while ready=1.
REQ-007 data_in  input  DATA_W  payload; latched on the accepting edge.
REQ-008 ready  output  1  high only in IDLE; indicates start will be accepted.
REQ-009 x_out  output  1  registered serial bit stream.
REQ-010 frame_active  output  1  high from the first sync bit through the gap bit.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The block SHALL be an FSM with states IDLE, SYNC, DATA, PARITY, GAP.
REQ-013 In IDLE: x_out=0, ready=1, frame_active=0.
REQ-014 On an edge with ready=1 and start=1, the block SHALL do all of the following: latch data_in into a shift register, enter SYNC, and drive SYNC[6] on x_out from the next cycle.
REQ-015 Each serial bit SHALL be held on x_out for exactly DIV cycles, timed by a divider counter.
REQ-016 The divider counter SHALL reload at each bit boundary.
REQ-017 SYNC SHALL emit 7 bits, SYNC[6] down to SYNC[0], then go to DATA.
REQ-018 DATA SHALL emit DATA_W bits, MSB first, from the latched payload, then go to PARITY.
REQ-019 PARITY SHALL emit one bit equal to the XOR of all latched payload bits (even parity), then go to GAP.
REQ-020 GAP SHALL emit one bit of 0, then return to IDLE.
REQ-021 Total frame length SHALL be (7+DATA_W+2)*DIV cycles; this is 17*DIV for the default DATA_W.
REQ-022 done SHALL be 1 for exactly the first IDLE cycle after GAP; ready=1 in that same cycle.
REQ-023 A start in the done cycle SHALL be accepted, so back-to-back frames are separated only by that single IDLE cycle with x_out=0.
REQ-024 start while ready=0 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-025 Changes on data_in after the accepting edge SHALL NOT affect the frame in flight.
REQ-026 The bit index counter SHALL be sized for max(7, DATA_W) and SHALL NOT wrap within a state.
REQ-027 Illegal or unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 While rst=1 at an edge, the block SHALL do all of the following, with rst taking priority over start: enter IDLE, and set x_out=0, ready=1, frame_active=0, done=0, divider=0, bit index=0.
REQ-029 Asserting rst mid-frame SHALL abort the frame with no done pulse; the first IDLE cycle after reset SHALL accept start.
REQ-030 At power-up (initial), all state SHALL equal the reset values.

Verification
REQ-031 DIV=1, data_in=8'hA5, start pulse -> x_out over 17 cycles = 1100110 10100101 0 0; done on cycle 18; frame_active high for cycles 1..17.
REQ-032 DIV=1, data_in=8'h07 -> payload bits 00000111, parity bit 1, gap 0.
REQ-033 DIV=4, data_in=8'h3C -> each bit held 4 cycles; 68 cycles of frame_active; done on cycle 69; parity bit 0.
REQ-034 Start pulses with data_in=8'hFF at frame cycles 3 and 10 of an 8'h00 frame -> frame content unchanged (payload 00000000, parity 0); no second frame starts.
REQ-035 rst=1 at frame cycle 9 (DIV=1) -> next cycle x_out=0, ready=1, frame_active=0, no done pulse; a new start then produces a complete, correct frame.
REQ-036 start held high continuously with data 8'h81 -> frames repeat every 18 cycles; the done cycle and the 1-cycle x_out=0 gap appear between frames; parity bit 0.
